pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB); successor to the fixed 2-source forwarding unit.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl_fwd_cmp.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Package hazard_pkg
// Purpose : shared constants for the pipeline hazard controller.
//           Forwarding select encodings and the bit layout of a scoreboard
//           entry. An entry holds the head fields {valid, regwrite, load, rd}
//           followed by the source addresses and their "actually read" flags.
// Ports   : none (package)
package hazard_pkg;

  // Forwarding select encodings driven per EX source operand
  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_RSVD = 2'd3;

  // Scoreboard entry bit offsets (head part, independent of parameters)
  localparam int E_VALID    = 0;
  localparam int E_REGWRITE = 1;
  localparam int E_LOAD     = 2;
  localparam int E_RD       = 3;

  // Width of the head part: valid, regwrite, load and rd
  function automatic int sb_head_width(input int reg_aw);
    return E_RD + reg_aw;
  endfunction

  // Full entry width: head, NUM_SRC source addresses, NUM_SRC used flags
  function automatic int sb_width(input int reg_aw, input int num_src);
    return E_RD + reg_aw + num_src * (reg_aw + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Interface pipe_hazard_ctrl_if
// Purpose : bundles the ID-stage instruction fields, pipeline status inputs
//           and hazard control outputs exchanged between the pipeline and
//           the hazard controller.
// Modports: master - pipeline side (drives ID fields and status, reads controls)
//           slave  - hazard controller side
// Signals : id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
//           ex_redirect, mem_ready, dbg_halt                       (to ctrl)
//           stall_if, stall_id, flush_id, bubble_ex, freeze, halted,
//           fwd_sel, perf_stall, perf_flush, perf_fwd              (from ctrl)
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
);

  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_rs;
  logic [NUM_SRC-1:0]          id_rs_used;
  logic [REG_AW-1:0]           id_rd;
  logic                        id_regwrite;
  logic                        id_memread;
  logic                        ex_redirect;
  logic                        mem_ready;
  logic                        dbg_halt;

  logic                        stall_if;
  logic                        stall_id;
  logic                        flush_id;
  logic                        bubble_ex;
  logic                        freeze;
  logic                        halted;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic [CNT_W-1:0]            perf_stall;
  logic [CNT_W-1:0]            perf_flush;
  logic [CNT_W-1:0]            perf_fwd;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
           ex_redirect, mem_ready, dbg_halt,
    input  stall_if, stall_id, flush_id, bubble_ex, freeze, halted,
           fwd_sel, perf_stall, perf_flush, perf_fwd
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
           ex_redirect, mem_ready, dbg_halt,
    output stall_if, stall_id, flush_id, bubble_ex, freeze, halted,
           fwd_sel, perf_stall, perf_flush, perf_fwd
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_cmp.sv
// Module hazard_fwd_cmp
// Purpose : forwarding select for one EX source operand, compared against
//           the MEM and WB scoreboard entries. MEM (younger) wins over WB.
// Ports   : rs, rs_used, ex_valid         - the EX source being resolved
//           mem_valid, mem_regwrite, mem_load, mem_rd - MEM entry
//           wb_valid, wb_regwrite, wb_rd  - WB entry
//           sel                           - FWD_RF / FWD_MEM / FWD_WB
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic              ex_valid,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic              mem_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);

  // A load sitting in MEM has no data yet; the load-use bubble guarantees
  // its consumer reaches EX only once the load is in WB, so it never matches.
  always_comb begin
    sel = FWD_RF;
    if (ex_valid && rs_used && (rs != '0)) begin
      if (mem_valid && mem_regwrite && !mem_load && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_valid && wb_regwrite && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Module pipe_hazard_ctrl
// Purpose : hazard controller for a 5-stage pipeline. Keeps an EX/MEM/WB
//           scoreboard of in-flight destinations, drives forwarding selects,
//           inserts load-use bubbles, squashes on EX redirects and freezes
//           the pipe on data-memory wait or debug halt.
//           Priority: freeze > redirect > load-use.
// Ports   : clk  - core clock
//           rstn - asynchronous active-low reset
//           hz   - pipe_hazard_ctrl_if.slave (ID fields, status, controls)
// Config  : HAZARD_PERF_CNT_EN - when defined, perf_stall/perf_flush/perf_fwd
//           are saturating event counters; otherwise they are tied to 0.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  pipe_hazard_ctrl_if.slave  hz
);
  import hazard_pkg::*;

  localparam int HEAD_W   = sb_head_width(REG_AW);
  localparam int ENT_W    = sb_width(REG_AW, NUM_SRC);
  localparam int RS_LSB   = HEAD_W;
  localparam int USED_LSB = HEAD_W + NUM_SRC * REG_AW;

  logic [ENT_W-1:0]     id_ent;
  logic [ENT_W-1:0]     ex_ent;
  logic [HEAD_W-1:0]    mem_ent;
  logic                 wb_valid;
  logic                 wb_regwrite;
  logic [REG_AW-1:0]    wb_rd;
  logic                 halted_q;

  logic                 ex_valid;
  logic [REG_AW-1:0]    ex_rd;
  logic                 freeze;
  logic                 redirect;
  logic                 rs_hit;
  logic                 load_use;
  logic                 capture;
  logic [NUM_SRC*2-1:0] fwd_sel;

  assign ex_valid = ex_ent[E_VALID];
  assign ex_rd    = ex_ent[E_RD +: REG_AW];

  // ID fields packed into scoreboard-entry layout
  always_comb begin
    id_ent                            = '0;
    id_ent[E_VALID]                   = 1'b1;
    id_ent[E_REGWRITE]                = hz.id_regwrite;
    id_ent[E_LOAD]                    = hz.id_memread;
    id_ent[E_RD +: REG_AW]            = hz.id_rd;
    id_ent[RS_LSB +: NUM_SRC*REG_AW]  = hz.id_rs;
    id_ent[USED_LSB +: NUM_SRC]       = hz.id_rs_used;
  end

  // Does any source the ID instruction actually reads hit the EX destination?
  always_comb begin
    rs_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hz.id_rs_used[k] && (hz.id_rs[k*REG_AW +: REG_AW] == ex_rd)) begin
        rs_hit = 1'b1;
      end
    end
  end

  // Freeze masks everything; a redirect masks the load-use stall because
  // the stalled ID instruction is squashed anyway.
  assign freeze   = !hz.mem_ready || hz.dbg_halt;
  assign redirect = hz.ex_redirect && ex_valid && !freeze;
  assign load_use = hz.id_valid && ex_valid && ex_ent[E_LOAD] &&
                    ex_ent[E_REGWRITE] && (ex_rd != '0) && rs_hit &&
                    !freeze && !redirect;

  assign capture  = hz.id_valid && !hz.stall_id && !hz.bubble_ex && !hz.flush_id;

  assign hz.stall_if  = freeze || load_use;
  assign hz.stall_id  = freeze || load_use;
  assign hz.flush_id  = redirect;
  assign hz.bubble_ex = redirect || load_use;
  assign hz.freeze    = freeze;
  assign hz.halted    = halted_q;
  assign hz.fwd_sel   = fwd_sel;

  // Scoreboard shifts only on non-frozen edges; WB keeps just what
  // forwarding needs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_ent      <= '0;
      mem_ent     <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
    end else if (!freeze) begin
      ex_ent      <= capture ? id_ent : '0;
      mem_ent     <= ex_ent[HEAD_W-1:0];
      wb_valid    <= mem_ent[E_VALID];
      wb_regwrite <= mem_ent[E_REGWRITE];
      wb_rd       <= mem_ent[E_RD +: REG_AW];
    end
  end

  // Halt is reported only once no data access is outstanding
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= hz.dbg_halt && hz.mem_ready;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp (
      .rs           (ex_ent[RS_LSB + k*REG_AW +: REG_AW]),
      .rs_used      (ex_ent[USED_LSB + k]),
      .ex_valid     (ex_valid),
      .mem_valid    (mem_ent[E_VALID]),
      .mem_regwrite (mem_ent[E_REGWRITE]),
      .mem_load     (mem_ent[E_LOAD]),
      .mem_rd       (mem_ent[E_RD +: REG_AW]),
      .wb_valid     (wb_valid),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .sel          (fwd_sel[2*k +: 2])
    );
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;
  logic [CNT_W-1:0] cnt_fwd;

  // Saturating event counters; a frozen cycle counts only as a stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_stall <= '0;
      cnt_flush <= '0;
      cnt_fwd   <= '0;
    end else begin
      if ((freeze || load_use) && (cnt_stall != '1)) begin
        cnt_stall <= cnt_stall + CNT_W'(1);
      end
      if (redirect && (cnt_flush != '1)) begin
        cnt_flush <= cnt_flush + CNT_W'(1);
      end
      if (!freeze && (fwd_sel != '0) && (cnt_fwd != '1)) begin
        cnt_fwd <= cnt_fwd + CNT_W'(1);
      end
    end
  end

  assign hz.perf_stall = cnt_stall;
  assign hz.perf_flush = cnt_flush;
  assign hz.perf_fwd   = cnt_fwd;
`else
  assign hz.perf_stall = '0;
  assign hz.perf_flush = '0;
  assign hz.perf_fwd   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench tb_pipe_hazard_ctrl
// Purpose : directed vectors for pipe_hazard_ctrl with hand-computed
//           expected controls, forwarding selects and counter values.
//           Counter expectations follow HAZARD_PERF_CNT_EN (0 when absent).
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  pipe_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(32)) hz ();

  pipe_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hz)
  );

  // {stall_if, stall_id, flush_id, bubble_ex, freeze, halted}
  logic [5:0] ctrl;
  assign ctrl = {hz.stall_if, hz.stall_id, hz.flush_id, hz.bubble_ex,
                 hz.freeze, hz.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value: n with counters built in, 0 otherwise
  function automatic logic [63:0] pc(input int n);
    return PERF_ON ? 64'(n) : 64'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs0,
                               input logic [4:0] rs1, input logic [1:0] used,
                               input logic [4:0] rd, input logic rw,
                               input logic ld);
    hz.id_valid    = v;
    hz.id_rs       = {rs1, rs0};
    hz.id_rs_used  = used;
    hz.id_rd       = rd;
    hz.id_regwrite = rw;
    hz.id_memread  = ld;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn           = 1'b0;
    hz.ex_redirect = 1'b0;
    hz.mem_ready   = 1'b1;
    hz.dbg_halt    = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ctrl", 64'(ctrl), 64'd0);
    checkOutput("rst_fwd", 64'(hz.fwd_sel), 64'd0);
    checkOutput("rst_perf_stall", 64'(hz.perf_stall), 64'd0);
    checkOutput("rst_perf_fwd", 64'(hz.perf_fwd), 64'd0);
    rstn = 1'b1;
    nextCycle();

    // add x1,x2,x3 ; add x2,x1,x1 ; add x3,x4,x1
    applyStimulus(1'b1, 5'd2, 5'd3, 2'b11, 5'd1, 1'b1, 1'b0);
    #1 checkOutput("fw_a_ctrl", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd1, 2'b11, 5'd2, 1'b1, 1'b0);
    #1 checkOutput("fw_b_fwd", 64'(hz.fwd_sel), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd4, 5'd1, 2'b11, 5'd3, 1'b1, 1'b0);
    #1 checkOutput("fw_mem_both", 64'(hz.fwd_sel), 64'b0101);
    checkOutput("fw_c_ctrl", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("fw_wb_src1", 64'(hz.fwd_sel), 64'b1000);
    checkOutput("fw_d_ctrl", 64'(ctrl), 64'd0);
    nextCycle();
    checkOutput("fw_perf_fwd", 64'(hz.perf_fwd), pc(2));
    idleCycles(3);

    // lw x5 ; add x6,x5,x0
    applyStimulus(1'b1, 5'd10, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
    #1 checkOutput("lu_a_ctrl", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0);
    #1 checkOutput("lu_stall", 64'(ctrl), 64'b110100);
    checkOutput("lu_fwd", 64'(hz.fwd_sel), 64'd0);
    nextCycle();
    #1 checkOutput("lu_once", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("lu_fwd_wb", 64'(hz.fwd_sel), 64'b0010);
    nextCycle();
    checkOutput("lu_perf_stall", 64'(hz.perf_stall), pc(1));
    checkOutput("lu_perf_fwd", 64'(hz.perf_fwd), pc(3));
    idleCycles(3);

    // x0 destination never forwards or stalls; unread sources never stall
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 5'd7, 1'b1, 1'b0);
    #1 checkOutput("x0_ctrl", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);
    #1 checkOutput("x0_fwd", 64'(hz.fwd_sel), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
    #1 checkOutput("x0_load_nostall", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd9, 2'b00, 5'd10, 1'b1, 1'b0);
    #1 checkOutput("unused_rs_nostall", 64'(ctrl), 64'd0);
    nextCycle();
    idleCycles(3);

    // Redirect with a simultaneous load-use: redirect wins
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0);
    hz.ex_redirect = 1'b1;
    #1 checkOutput("rd_flush", 64'(ctrl), 64'b001100);
    nextCycle();
    hz.ex_redirect = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("rd_after", 64'(ctrl), 64'd0);
    checkOutput("rd_perf_flush", 64'(hz.perf_flush), pc(1));
    checkOutput("rd_perf_stall", 64'(hz.perf_stall), pc(1));
    nextCycle();

    // add x11 ; sw x3,(x11) ; add x12,x11 ; memory wait 3 cycles
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 5'd11, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd11, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd11, 5'd0, 2'b11, 5'd12, 1'b1, 1'b0);
    #1 checkOutput("sw_fwd_mem", 64'(hz.fwd_sel), 64'b0001);
    nextCycle();
    applyStimulus(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0);
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("frz_ctrl", 64'(ctrl), 64'b110010);
      checkOutput("frz_fwd", 64'(hz.fwd_sel), 64'b0010);
      nextCycle();
    end
    hz.mem_ready = 1'b1;
    #1 checkOutput("frz_release", 64'(ctrl), 64'd0);
    checkOutput("frz_hold_fwd", 64'(hz.fwd_sel), 64'b0010);
    nextCycle();
    checkOutput("frz_perf_stall", 64'(hz.perf_stall), pc(4));
    checkOutput("frz_perf_fwd", 64'(hz.perf_fwd), pc(5));

    // Debug halt requested during a memory wait
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    hz.mem_ready = 1'b0;
    hz.dbg_halt  = 1'b1;
    #1 checkOutput("hlt_wait0", 64'(ctrl), 64'b110010);
    nextCycle();
    #1 checkOutput("hlt_wait1", 64'(ctrl), 64'b110010);
    nextCycle();
    hz.mem_ready = 1'b1;
    #1 checkOutput("hlt_done", 64'(ctrl), 64'b110010);
    nextCycle();
    #1 checkOutput("hlt_on", 64'(ctrl), 64'b110011);
    checkOutput("hlt_fwd", 64'(hz.fwd_sel), 64'b0001);
    nextCycle();
    hz.dbg_halt = 1'b0;
    #1 checkOutput("hlt_release", 64'(ctrl), 64'b000001);
    checkOutput("hlt_resume_fwd", 64'(hz.fwd_sel), 64'b0001);
    nextCycle();
    #1 checkOutput("hlt_resumed", 64'(ctrl), 64'd0);
    checkOutput("hlt_perf_stall", 64'(hz.perf_stall), pc(8));
    checkOutput("hlt_perf_fwd", 64'(hz.perf_fwd), pc(6));
    nextCycle();

    // Reset in the middle of a load-use stall and of a halt
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0);
    #1 checkOutput("rst_pre_stall", 64'(ctrl), 64'b110100);
    #1 rstn = 1'b0;
    #1 checkOutput("rst_mid_stall", 64'(ctrl), 64'd0);
    checkOutput("rst_perf_clr", 64'(hz.perf_stall), 64'd0);
    nextCycle();
    rstn = 1'b1;
    #1 checkOutput("rst_first_instr", 64'(ctrl), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    hz.dbg_halt = 1'b1;
    nextCycle();
    #1 checkOutput("rst_halt_on", 64'(ctrl), 64'b110011);
    hz.dbg_halt = 1'b0;
    rstn = 1'b0;
    #1 checkOutput("rst_mid_halt", 64'(ctrl), 64'd0);
    nextCycle();
    rstn = 1'b1;
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
